// File: rtl/vdp_irq_pkg.sv
// Shared constants and helpers for the multi-source VDP interrupt block.
// Optional overrun tracking is built when VDP_IRQ_OVERRUN_EN is defined.
package vdp_irq_pkg;

  localparam int NCH_DEF   = 4;

  localparam int CH_VBLANK = 0;
  localparam int CH_LINE   = 1;
  localparam int CH_COLL   = 2;
  localparam int CH_5S     = 3;

  // Sized for the widest build; the top slices to NCH.
  localparam logic [7:0] CLR_ON_RD_DEF = 8'hFF;
  localparam logic [7:0] EN_RESET_DEF  = 8'h01;

  // A new event beats any clear landing in the same cycle.
  function automatic logic flag_next(
    input logic tick,
    input logic clr,
    input logic cur
  );
    return tick | (cur & ~clr);
  endfunction

endpackage

// File: rtl/vdp_irq_chan.sv
// One sticky interrupt flag cell with set-over-clear priority.
// With VDP_IRQ_OVERRUN_EN, also tracks a sticky overrun bit.
module vdp_irq_chan
  import vdp_irq_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic tick_i,
  input  logic clr_i,
`ifdef VDP_IRQ_OVERRUN_EN
  output logic ovr_o,
`endif
  output logic flag_o
);

  logic flag_q;
  logic flag_d;

  always_comb begin
    flag_d = flag_next(tick_i, clr_i, flag_q);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) flag_q <= 1'b0;
    else       flag_q <= flag_d;
  end

  assign flag_o = flag_q;

`ifdef VDP_IRQ_OVERRUN_EN
  logic ovr_q;
  logic ovr_d;

  // A second event while still pending, and not being drained, overruns.
  always_comb begin
    ovr_d = (tick_i & flag_q & ~clr_i) | (ovr_q & ~clr_i);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ovr_q <= 1'b0;
    else       ovr_q <= ovr_d;
  end

  assign ovr_o = ovr_q;
`endif

endmodule

// File: rtl/vdp_irq_multi.sv
// Multi-channel VDP interrupt latch: sticky flags, enable mask, one irq.
// Define VDP_IRQ_OVERRUN_EN to add the per-channel overrun output.
module vdp_irq_multi
  import vdp_irq_pkg::*;
#(
  parameter int               NCH       = NCH_DEF,
  parameter logic [NCH-1:0]   CLR_ON_RD = CLR_ON_RD_DEF[NCH-1:0],
  parameter logic [NCH-1:0]   EN_RESET  = EN_RESET_DEF[NCH-1:0]
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [NCH-1:0] irq_tick,
  input  logic           rd_tick,
  input  logic [NCH-1:0] ack,
  input  logic           en_wr,
  input  logic [NCH-1:0] en_data,
  output logic [NCH-1:0] status,
  output logic [NCH-1:0] enable,
`ifdef VDP_IRQ_OVERRUN_EN
  output logic [NCH-1:0] overrun,
`endif
  output logic           irq
);

  logic [NCH-1:0] clr;
  logic [NCH-1:0] flag;
  logic [NCH-1:0] enable_q;
  logic [NCH-1:0] enable_d;

  assign clr = ack | ({NCH{rd_tick}} & CLR_ON_RD);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    vdp_irq_chan u_chan (
      .clk_i  (clk),
      .rst_i  (reset),
      .tick_i (irq_tick[i]),
      .clr_i  (clr[i]),
`ifdef VDP_IRQ_OVERRUN_EN
      .ovr_o  (overrun[i]),
`endif
      .flag_o (flag[i])
    );
  end

  always_comb begin
    enable_d = enable_q;
    if (en_wr) enable_d = en_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) enable_q <= EN_RESET;
    else       enable_q <= enable_d;
  end

  assign status = flag;
  assign enable = enable_q;
  assign irq    = |(flag & enable_q);

endmodule

// File: doc/vdp_irq_multi.md
Name: vdp_irq_multi

Overview:
- Multi-source successor to the single-flag VDP interrupt latch.
- Holds NCH sticky event flags (vblank, line, sprite collision, 5th sprite, ...) with a CPU-writable enable mask.
- Status register is clear-on-read, per channel under the CLR_ON_RD mask; explicit per-channel ack also clears.
- Drives one active-high irq to the CPU interrupt logic; sits between the VDP timing/sprite engines and the CPU bus interface.

Parameters:
- NCH, 4, number of interrupt channels (1..8).
- CLR_ON_RD, 4'b1111, per-channel mask; bit=1 means rd_tick clears that flag.
- EN_RESET, 4'b0001, enable mask value after reset (vblank only).

Ports:
- clk  in  1  pixel clock; all state on posedge.
- reset  in  1  asynchronous, active-high; clears all state.
- irq_tick  in  NCH  one-clk event pulse per channel from the VDP engines.
- rd_tick  in  1  one-clk CPU status read strobe.
- ack  in  NCH  one-clk explicit per-channel clear, independent of CLR_ON_RD.
- en_wr  in  1  one-clk write strobe for the enable mask.
- en_data  in  NCH  new enable mask, sampled when en_wr=1.
- status  out  NCH  current flags, combinational from the flag register; the CPU samples it during the rd_tick cycle.
- enable  out  NCH  current enable mask register.
- irq  out  1  |(flag & enable), combinational from registers only; no input feeds it combinationally.

Behaviour:
- Reset (asynchronous): flag=0, enable=EN_RESET, irq=0, status=0; overrun=0 if the optional feature is built.
- Per channel i, on each posedge:
  - If irq_tick[i]: flag[i] <= 1. Set beats every clear source.
  - Else if ack[i], or (rd_tick and CLR_ON_RD[i]): flag[i] <= 0.
  - Else: hold.
- Read/tick in the same cycle: status[i] shows the pre-edge value to the read; the flag is 1 after the edge. The event is never lost and is reported by the next read.
- Read when the flag is already 1 and irq_tick[i] arrives in the same cycle: the read sees 1 and the flag stays 1. The second event is preserved.
- Continuous rd_tick: flags stay 0 and no spurious irq. Continuous rd_tick plus irq_tick: the flag stays 1.
- Latency:
  - irq_tick to irq high: 1 clk, when enabled.
  - Clearing rd_tick/ack to irq low: 1 clk, provided no other enabled flag is pending.
- en_wr: enable <= en_data, taking effect on irq the next clk.
  - Enabling a channel with a pending flag asserts irq after that edge.
  - Disabling drops irq but keeps the flag, which stays visible in status.
  - Ticks on disabled channels still set their flags.
- en_wr in the same cycle as rd_tick/irq_tick: the operations are independent, and each register applies its own rule.
- Reset asserted mid-operation: immediate clear regardless of clk; pulses coincident with reset are discarded.
- Channels with CLR_ON_RD[i]=0 (e.g. collision) clear only via ack[i].

Optional Feature:
- Macro: VDP_IRQ_OVERRUN_EN.
- With the macro:
  - Adds overrun output (NCH), a per-channel sticky bit.
  - overrun[i] <= 1 when irq_tick[i] occurs while flag[i]=1 and flag[i] is not being cleared in that same cycle.
  - overrun[i] is cleared under the same clear conditions as flag[i]; a coincident new overrun wins.
  - Reset value 0.
- Without the macro: the port and logic are absent, and all other behaviour is identical.

Decomposition:
- Package vdp_irq_pkg holds:
  - Channel index constants: CH_VBLANK=0, CH_LINE=1, CH_COLL=2, CH_5S=3.
  - Default NCH=4.
  - Default CLR_ON_RD and EN_RESET masks.
- Sub-module vdp_irq_chan: one flag cell (set/clear priority, optional overrun), instantiated NCH times by generate.
- The top level owns the enable register and the irq OR-reduction.

Test Plan:
- Reset, then rd_tick with no events -> status=0000, irq=0. Hold rd_tick 3 clks -> irq stays 0.
- irq_tick=0001 for 1 clk -> irq=1 one clk later and stays 1 for 5 idle clks. rd_tick -> status=0001 sampled, irq=0 next clk.
- rd_tick and irq_tick=0001 in the same clk -> read sees status=0000, irq=1 after the edge. Next rd_tick sees 0001, then irq=0.
- EN default 0001; irq_tick=0010 -> status=0010, irq=0. Then en_wr with en_data=0011 -> irq=1 the next clk. en_wr with 0001 -> irq=0, status still 0010.
- CLR_ON_RD=0111 with irq_tick=1000 -> rd_tick leaves status=1000. ack=1000 -> status=0000.
- VDP_IRQ_OVERRUN_EN built: two irq_tick=0001 pulses without a read -> overrun=0001. rd_tick -> overrun=0000. Assert reset mid-sequence -> all outputs 0 immediately.
